multicycle_controller: RTL
==========================

// Module: multicycle_controller
// PURPOSE
//  Moore FSM sequencing the shared multicycle RV32I datapath (one ALU, one unified memory port).
//  Steps each instruction through FETCH/DECODE/EXECUTE/MEM/WB and drives every datapath enable and mux select.
//  Supports lw, sw, R-type, I-type ALU, jal and beq.
//  Includes its own ALU-control and immediate-select decode. Sits beside the datapath in the multicycle core top.
// PARAMETERS
//  WAIT_MEM  1  1: honour mem_ready in memory states; 0: mem_ready ignored, treated as 1
// PORTS
//  clk         in   1  sole clock, rising edge
//  reset       in   1  synchronous, active-high
//  Op          in   7  instr[6:0] from IR
//  funct3      in   3  instr[14:12]
//  funct7      in   1  instr[30]
//  Zero        in   1  ALU zero flag
//  mem_ready   in   1  memory access completes this cycle
//  PCWrite     out  1  PC register enable
//  AdrSrc      out  1  memory address select: 0=PC, 1=ALUOut
//  MemWrite    out  1  memory write strobe
//  IRWrite     out  1  IR/OldPC enable
//  RegWrite    out  1  register-file write enable
//  ResultSrc   out  2  00=ALUOut, 01=Data, 10=ALUResult
//  ALUSrcA     out  2  00=PC, 01=OldPC, 10=rs1
//  ALUSrcB     out  2  00=rs2, 01=ImmExt, 10=const 4
//  ImmSrc      out  2  00=I, 01=S, 10=B, 11=J
//  ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
//  state_o     out  4  current state encoding, for debug/bench
// BEHAVIOUR
//  - Reset: state<=FETCH(0). While reset=1, PCWrite/IRWrite/MemWrite/RegWrite are forced 0; selects show FETCH values.
//  - States and outputs (unlisted outputs = 0); X = ALUSrcA/ALUSrcB/ALUOp:
//    0 FETCH: AdrSrc=0, IRWrite, X=00/10/00, ResultSrc=10, PCUpdate -> DECODE
//    1 DECODE: X=01/01/00 -> by Op: 0000011|0100011 MEMADR; 0110011 EXECR; 0010011 EXECI;
//      1101111 JAL; 1100011 BEQ; other -> see CONFIGURATION
//    2 MEMADR: X=10/01/00 -> Op[5]=0 MEMREAD, Op[5]=1 MEMWRITE
//    3 MEMREAD: ResultSrc=00, AdrSrc=1 -> MEMWB
//    4 MEMWB: ResultSrc=01, RegWrite -> FETCH
//    5 MEMWRITE: ResultSrc=00, AdrSrc=1, MemWrite -> FETCH
//    6 EXECR: X=10/00/10 -> ALUWB
//    7 ALUWB: ResultSrc=00, RegWrite -> FETCH
//    8 EXECI: X=10/01/10 -> ALUWB
//    9 JAL: X=01/10/00, ResultSrc=00, PCUpdate -> ALUWB
//    10 BEQ: X=10/00/01, ResultSrc=00, Branch -> FETCH
//    11 TRAP: all enables 0; terminal until reset (macro only)
//  - PCWrite = PCUpdate | (Branch & Zero).
//  - mem_ready (WAIT_MEM=1): FETCH/MEMREAD/MEMWRITE hold state while mem_ready=0.
//    FETCH IRWrite/PCWrite assert only in the cycle mem_ready=1.
//    MemWrite and AdrSrc stay asserted through the whole MEMWRITE wait.
//  - ALUControl decode: ALUOp 00->000; 01->001; 10 by funct3:
//    000 -> 001 if {Op[5],funct7}==11, else 000; 010->101; 110->011; 111->010; other->000. ALUOp 11->000.
//  - ImmSrc is combinational from Op, valid in every state: 0100011->01, 1100011->10, 1101111->11, else 00.
//  - Latency (WAIT_MEM=0): lw 5, sw 4, R/I 4, jal 4, beq 3 cycles.
//  - Reset mid-instruction: next edge -> FETCH; no partial writes occur after reset sampled.
// CONFIGURATION
//  MC_CTRL_ILLEGAL_TRAP_EN defined:
//    unsupported Op in DECODE -> TRAP(11); adds output illegal_instr (1 bit), 1 in TRAP, 0 after reset.
//  Undefined: unsupported Op in DECODE -> FETCH (NOP); no illegal_instr port; state 11 unreachable.
// TESTING
//  1 reset=1 for 2 cycles -> state_o=0, all 4 enables 0; release -> IRWrite=PCWrite=1 next cycle (mem_ready=1).
//  2 lw (Op=0000011) -> states 0,1,2,3,4,0; RegWrite=1 and ResultSrc=01 only in state 4.
//  3 R-type sub (Op=0110011, funct3=000, funct7=1) -> ALUControl=001 in EXECR;
//    funct7=0 -> 000; I-type addi with funct7=1 -> 000.
//  4 beq with Zero=1 -> PCWrite=1 in BEQ; Zero=0 -> PCWrite=0; both return to FETCH.
//  5 sw with mem_ready low 3 cycles -> stays in MEMWRITE 4 cycles, MemWrite=1 throughout, then FETCH.
//  6 Op=1111111 -> FETCH (undefined) / TRAP with illegal_instr=1 (defined);
//    reset asserted in TRAP -> FETCH next cycle.

Source files
------------

// File: rtl/multicycle_controller.sv
// Moore control FSM for the shared multicycle RV32I datapath, with ALU-control and ImmSrc decode.
// Optional feature: define MC_CTRL_ILLEGAL_TRAP_EN to trap unsupported opcodes and add illegal_instr.
module multicycle_controller #(
  parameter int unsigned WAIT_MEM = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] Op,
  input  logic [2:0] funct3,
  input  logic       funct7,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic [3:0] state_o
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  ,
  output logic       illegal_instr
`endif
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECI    = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10,
    S_TRAP     = 4'd11
  } state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  localparam state_t ILLEGAL_NEXT = S_TRAP;
`else
  localparam state_t ILLEGAL_NEXT = S_FETCH;
`endif

  state_t     state_q, state_d, out_state;
  logic       mem_ok;
  logic       pc_update, branch;
  logic       ir_write_raw, reg_write_raw, mem_write_raw;
  logic [1:0] alu_op;

  assign mem_ok = (WAIT_MEM == 0) ? 1'b1 : mem_ready;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // NOTE: each combinational output is given a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    if (mem_ok) state_d = S_DECODE;
      S_DECODE: begin
        case (Op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECR;
          OP_ITYPE:          state_d = S_EXECI;
          OP_JAL:            state_d = S_JAL;
          OP_BEQ:            state_d = S_BEQ;
          default:           state_d = ILLEGAL_NEXT;
        endcase
      end
      S_MEMADR:   state_d = Op[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (mem_ok) state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: if (mem_ok) state_d = S_FETCH;
      S_EXECR:    state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_EXECI:    state_d = S_ALUWB;
      S_JAL:      state_d = S_ALUWB;
      S_BEQ:      state_d = S_FETCH;
      S_TRAP:     state_d = ILLEGAL_NEXT;
      default:    state_d = S_FETCH;
    endcase
  end

  // While reset is high the selects decode as FETCH and every write enable is masked.
  assign out_state = reset ? S_FETCH : state_q;

  always_comb begin
    pc_update     = 1'b0;
    branch        = 1'b0;
    ir_write_raw  = 1'b0;
    reg_write_raw = 1'b0;
    mem_write_raw = 1'b0;
    AdrSrc        = 1'b0;
    ResultSrc     = 2'b00;
    ALUSrcA       = 2'b00;
    ALUSrcB       = 2'b00;
    alu_op        = 2'b00;
    case (out_state)
      S_FETCH: begin
        ir_write_raw = mem_ok;
        pc_update    = mem_ok;
        ALUSrcB      = 2'b10;
        ResultSrc    = 2'b10;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      S_MEMREAD:  AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc     = 2'b01;
        reg_write_raw = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc        = 1'b1;
        mem_write_raw = 1'b1;
      end
      S_EXECR: begin
        ALUSrcA = 2'b10;
        alu_op  = 2'b10;
      end
      S_ALUWB:    reg_write_raw = 1'b1;
      S_EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        alu_op  = 2'b10;
      end
      S_JAL: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        pc_update = 1'b1;
      end
      S_BEQ: begin
        ALUSrcA = 2'b10;
        alu_op  = 2'b01;
        branch  = 1'b1;
      end
      default: ;
    endcase
  end

  assign PCWrite  = (pc_update | (branch & Zero)) & ~reset;
  assign IRWrite  = ir_write_raw & ~reset;
  assign RegWrite = reg_write_raw & ~reset;
  assign MemWrite = mem_write_raw & ~reset;

  // ALUOp 10 decodes funct3; funct7 selects sub only for register-register ops (Op[5]=1).
  always_comb begin
    ALUControl = 3'b000;
    case (alu_op)
      2'b01: ALUControl = 3'b001;
      2'b10: begin
        case (funct3)
          3'b000:  ALUControl = ({Op[5], funct7} == 2'b11) ? 3'b001 : 3'b000;
          3'b010:  ALUControl = 3'b101;
          3'b110:  ALUControl = 3'b011;
          3'b111:  ALUControl = 3'b010;
          default: ALUControl = 3'b000;
        endcase
      end
      default: ALUControl = 3'b000;
    endcase
  end

  always_comb begin
    case (Op)
      OP_STORE: ImmSrc = 2'b01;
      OP_BEQ:   ImmSrc = 2'b10;
      OP_JAL:   ImmSrc = 2'b11;
      default:  ImmSrc = 2'b00;
    endcase
  end

  assign state_o = state_q;

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  assign illegal_instr = (state_q == S_TRAP);
`endif

endmodule
